// File: rtl/ratio_meter.sv
// Measures F_input cycles across 100 reference periods and reports the ratio in
// 25.7 C_N format. Natural = count/100 and Decimal = count%100, with no divider.
module ratio_meter #(
  parameter int          SYNC_STAGES = 2,
  parameter int          NAT_W       = 25,
  parameter logic [31:0] RESET_CN    = 32'h0000_0100
) (
  input  logic        F_input,
  input  logic        Reset,
  input  logic        En,
  input  logic        F_ref,
  output logic [31:0] C_N,
  output logic        Valid,
  output logic        Overflow,
  output logic        Busy
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  localparam logic [NAT_W-1:0] NAT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   last_d;
  logic                   edge_r;

  state_t           state, state_n;
  logic [6:0]       dec, dec_n, dec_inc;
  logic [NAT_W-1:0] nat, nat_n, nat_inc;
  logic [6:0]       periods, periods_n;
  logic             sat, sat_n, sat_inc;
  logic [31:0]      cn_n;
  logic             valid_n, ovf_n;

  always_ff @(posedge F_input or posedge Reset) begin
    if (Reset) begin
      sync   <= '0;
      last_d <= 1'b0;
      edge_r <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], F_ref};
      last_d <= sync[SYNC_STAGES-1];
      edge_r <= sync[SYNC_STAGES-1] & ~last_d;
    end
  end

  // Count including the current cycle; Dec wraps 99->0 and carries into Natural.
  always_comb begin
    dec_inc = dec + 7'd1;
    nat_inc = nat;
    sat_inc = sat;
    if (dec == 7'd99) begin
      dec_inc = '0;
      if (nat == NAT_MAX) sat_inc = 1'b1;
      else                nat_inc = nat + 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    dec_n     = dec;
    nat_n     = nat;
    periods_n = periods;
    sat_n     = sat;
    cn_n      = C_N;
    ovf_n     = Overflow;
    valid_n   = 1'b0;
    if (!En) begin
      state_n   = IDLE;
      dec_n     = '0;
      nat_n     = '0;
      periods_n = '0;
      sat_n     = 1'b0;
    end else begin
      case (state)
        IDLE: state_n = ARM;
        ARM: begin
          if (edge_r) begin
            dec_n     = '0;
            nat_n     = '0;
            periods_n = '0;
            sat_n     = 1'b0;
            state_n   = MEASURE;
          end
        end
        MEASURE: begin
          if (edge_r && periods == 7'd99) begin
            // Closing edge doubles as the next opening edge: no gap between windows.
            cn_n = '0;
            if (sat_inc) cn_n[NAT_W+6:0] = {NAT_MAX, 7'd99};
            else         cn_n[NAT_W+6:0] = {nat_inc, dec_inc};
            ovf_n     = sat_inc;
            valid_n   = 1'b1;
            dec_n     = '0;
            nat_n     = '0;
            periods_n = '0;
            sat_n     = 1'b0;
          end else begin
            dec_n = dec_inc;
            nat_n = nat_inc;
            sat_n = sat_inc;
            if (edge_r) periods_n = periods + 7'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge F_input or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      dec      <= '0;
      nat      <= '0;
      periods  <= '0;
      sat      <= 1'b0;
      C_N      <= RESET_CN;
      Valid    <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      state    <= state_n;
      dec      <= dec_n;
      nat      <= nat_n;
      periods  <= periods_n;
      sat      <= sat_n;
      C_N      <= cn_n;
      Valid    <= valid_n;
      Overflow <= ovf_n;
    end
  end

  assign Busy = (state == MEASURE);

endmodule

// File: tb/tb_ratio_meter.sv
// Directed bench for ratio_meter: a default instance and a NAT_W=4 instance share stimulus.
module tb_ratio_meter;

  logic        clk = 1'b0;
  logic        rst, en, f_ref;
  logic [31:0] cn_a, cn_b;
  logic        valid_a, valid_b, ovf_a, ovf_b, busy_a, busy_b;

  always #10 clk = ~clk;

  ratio_meter #(.SYNC_STAGES(2), .NAT_W(25), .RESET_CN(32'h0000_0100)) dut_a (
    .F_input(clk), .Reset(rst), .En(en), .F_ref(f_ref),
    .C_N(cn_a), .Valid(valid_a), .Overflow(ovf_a), .Busy(busy_a)
  );

  ratio_meter #(.SYNC_STAGES(2), .NAT_W(4), .RESET_CN(32'h0000_0100)) dut_b (
    .F_input(clk), .Reset(rst), .En(en), .F_ref(f_ref),
    .C_N(cn_b), .Valid(valid_b), .Overflow(ovf_b), .Busy(busy_b)
  );

  typedef struct {
    logic        va, vb;
    logic [31:0] ca, cb;
    logic        oa, ob;
    int          cyc;
  } ev_t;

  typedef struct {
    int          p1, p2, ph;
    logic [31:0] cn_a;
    logic        ovf_a;
    logic [31:0] cn_b;
    logic        ovf_b;
  } vec_t;

  ev_t  q[$];
  vec_t vt[16];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_bad = 0;
  int   edge_cyc;

  always @(posedge clk) cyc++;

  always @(negedge clk)
    if (valid_a || valid_b)
      q.push_back('{va: valid_a, vb: valid_b, ca: cn_a, cb: cn_b, oa: ovf_a, ob: ovf_b, cyc: cyc});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One ref period of p cycles; entered and left at posedge+ph.
  task automatic ref_period(input int p, input int ph);
    f_ref = 1'b1;
    repeat (p / 2) @(posedge clk);
    #ph f_ref = 1'b0;
    repeat (p - p / 2) @(posedge clk);
    #ph;
  endtask

  task automatic restart(input int ph);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #ph en = 1'b1;
    q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    restart(v.ph);
    for (int i = 0; i <= 100; i++) begin
      if (i == 100) edge_cyc = cyc;
      ref_period((i < 50) ? v.p1 : v.p2, v.ph);
    end
    repeat (4) @(posedge clk);
    chk("valid_count", q.size(), 1);
    if (q.size() >= 1) begin
      chk("valid_both", {q[0].va, q[0].vb}, 2'b11);
      chk("cn_a", q[0].ca, v.cn_a);
      chk("ovf_a", q[0].oa, v.ovf_a);
      chk("cn_b", q[0].cb, v.cn_b);
      chk("ovf_b", q[0].ob, v.ovf_b);
      chk("latency", q[0].cyc - edge_cyc, 4);
    end
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; f_ref = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cn_a", cn_a, 32'h0000_0100);
    chk("rst_cn_b", cn_b, 32'h0000_0100);
    chk("rst_flags_a", {valid_a, ovf_a, busy_a}, 3'b000);
    chk("rst_flags_b", {valid_b, ovf_b, busy_b}, 3'b000);
    @(posedge clk);
    #5 rst = 1'b0;

    vt[0] = '{p1: 8,  p2: 8,  ph: 5, cn_a: 32'h0000_0400, ovf_a: 1'b0, cn_b: 32'h0000_0400, ovf_b: 1'b0};
    vt[1] = '{p1: 8,  p2: 9,  ph: 5, cn_a: 32'h0000_0432, ovf_a: 1'b0, cn_b: 32'h0000_0432, ovf_b: 1'b0};
    vt[2] = '{p1: 20, p2: 20, ph: 5, cn_a: 32'h0000_0A00, ovf_a: 1'b0, cn_b: 32'h0000_07E3, ovf_b: 1'b1};
    vt[3] = '{p1: 10, p2: 10, ph: 5, cn_a: 32'h0000_0500, ovf_a: 1'b0, cn_b: 32'h0000_0500, ovf_b: 1'b0};
    vt[4] = '{p1: 16, p2: 16, ph: 7, cn_a: 32'h0000_0800, ovf_a: 1'b0, cn_b: 32'h0000_07E3, ovf_b: 1'b1};
    vt[5] = '{p1: 15, p2: 15, ph: 7, cn_a: 32'h0000_0780, ovf_a: 1'b0, cn_b: 32'h0000_0780, ovf_b: 1'b0};
    for (int i = 0; i < 10; i++)
      vt[6 + i] = '{p1: 13, p2: 13, ph: 1 + 2 * i, cn_a: 32'h0000_0680, ovf_a: 1'b0,
                    cn_b: 32'h0000_0680, ovf_b: 1'b0};

    for (int i = 0; i < 16; i++) run_vec(vt[i]);

    // Continuous measurement: back-to-back windows 800 cycles apart.
    restart(5);
    for (int i = 0; i < 201; i++) ref_period(8, 5);
    repeat (4) @(posedge clk);
    chk("b2b_count", q.size(), 2);
    if (q.size() == 2) begin
      chk("b2b_cn0", q[0].ca, 32'h0000_0400);
      chk("b2b_cn1", q[1].ca, 32'h0000_0400);
      chk("b2b_spacing", q[1].cyc - q[0].cyc, 800);
    end
    chk("b2b_busy", busy_a, 1'b1);

    // En dropped at Periods=60 for 5 cycles, then a fresh window at period 9.
    restart(5);
    for (int i = 0; i < 61; i++) ref_period(8, 5);
    chk("drop_busy_before", busy_a, 1'b1);
    en = 1'b0;
    repeat (5) @(posedge clk);
    chk("drop_busy_low", busy_a, 1'b0);
    chk("drop_cn_held", cn_a, 32'h0000_0400);
    #5 en = 1'b1;
    for (int i = 0; i < 101; i++) ref_period(9, 5);
    repeat (4) @(posedge clk);
    chk("rearm_count", q.size(), 1);
    if (q.size() >= 1) chk("rearm_cn", q[0].ca, 32'h0000_0480);

    // En falls on the closing-edge cycle: no update.
    restart(5);
    for (int i = 0; i < 100; i++) ref_period(8, 5);
    f_ref = 1'b1;
    repeat (3) @(posedge clk);
    #5 en = 1'b0;
    repeat (4) @(posedge clk);
    #5 f_ref = 1'b0;
    repeat (6) @(posedge clk);
    chk("close_en_low_count", q.size(), 0);
    chk("close_en_low_cn", cn_a, 32'h0000_0480);

    // Reset mid-window, then a full fresh window at period 10.
    restart(5);
    for (int i = 0; i < 50; i++) ref_period(8, 5);
    chk("pre_rst_busy", busy_a, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_cn_a", cn_a, 32'h0000_0100);
    chk("mid_rst_cn_b", cn_b, 32'h0000_0100);
    chk("mid_rst_flags", {valid_a, busy_a, busy_b}, 3'b000);
    @(posedge clk);
    #5 rst = 1'b0;
    q.delete();
    for (int i = 0; i < 101; i++) ref_period(10, 5);
    repeat (4) @(posedge clk);
    chk("post_rst_count", q.size(), 1);
    if (q.size() >= 1) chk("post_rst_cn", q[0].ca, 32'h0000_0500);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
